// File: rtl/anc_sample_sequencer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : anc_sample_sequencer
// Description : Per-sample ANC control FSM; time-shares one MAC between the
//               FIR output pass and the LMS weight-update pass.
// Revision    : 1.0 - initial release
// ============================================================================
module anc_sample_sequencer #(
  parameter int NTAPS = 32,
  parameter int PIPE  = 2,
  parameter int ACCW  = 40,
  parameter int SHIFT = 15,
  localparam int TW   = $clog2(NTAPS)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   init_done,
  input  logic                   bypass_mode_sel,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic signed [15:0]     e_in,
  input  logic signed [15:0]     x_in,
  input  logic signed [15:0]     a_in,
  input  logic signed [15:0]     u_in,
  output logic signed [15:0]     x_cur,
  output logic signed [15:0]     mu_e,
  output logic                   mac_en,
  output logic                   mac_op,
  output logic [TW-1:0]          tap_idx,
  output logic                   acc_clr,
  output logic                   shift_en,
  input  logic signed [ACCW-1:0] acc_in,
  output logic signed [15:0]     out_sample,
  output logic                   out_valid,
  output logic                   busy,
  output logic [7:0]             overrun_cnt
);

  // One counter serves both the tap sweep and the pipeline drain.
  localparam int CW = (TW > $clog2(PIPE + 1)) ? TW : $clog2(PIPE + 1);
  localparam logic [CW-1:0]          C_TAP_LAST  = CW'(NTAPS - 1);
  localparam logic [CW-1:0]          C_PIPE_LAST = CW'(PIPE - 1);
  localparam logic signed [31:0]     C_P_MAX     = 32'sd32767;
  localparam logic signed [31:0]     C_P_MIN     = -32'sd32768;
  localparam logic signed [ACCW:0]   C_O_MAX     = (ACCW + 1)'(32767);
  localparam logic signed [ACCW:0]   C_O_MIN     = (ACCW + 1)'(-32768);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_CAPTURE = 3'd1,
    S_FIR     = 3'd2,
    S_FDRAIN  = 3'd3,
    S_OUTPUT  = 3'd4,
    S_LMS     = 3'd5,
    S_LDRAIN  = 3'd6
  } state_t;

  state_t                r_state;
  state_t                w_next;
  logic [CW-1:0]         r_cnt;
  logic signed [15:0]    r_e;
  logic signed [15:0]    r_a;
  logic signed [15:0]    r_u;
  logic signed [15:0]    r_x_cur;
  logic signed [15:0]    r_mu_e;
  logic signed [15:0]    r_out_sample;
  logic                  r_out_valid;
  logic                  r_bypass;
  logic                  r_in_valid_q;
  logic [7:0]            r_overrun_cnt;
  logic                  w_accept;
  logic signed [31:0]    w_prod;
  logic signed [31:0]    w_prod_sh;
  logic signed [15:0]    w_mu_sat;
  logic signed [ACCW-1:0] w_acc_sh;
  logic signed [ACCW:0]  w_diff;
  logic signed [15:0]    w_out_sat;

  // Reset gates in_ready so nothing is advertised while held in reset.
  assign in_ready    = rst_n & init_done & (r_state == S_IDLE);
  assign w_accept    = in_valid & in_ready;
  assign busy        = (r_state != S_IDLE);
  assign x_cur       = r_x_cur;
  assign mu_e        = r_mu_e;
  assign out_sample  = r_out_sample;
  assign out_valid   = r_out_valid;
  assign overrun_cnt = r_overrun_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next   = r_state;
    mac_en   = 1'b0;
    mac_op   = 1'b0;
    tap_idx  = '0;
    acc_clr  = 1'b0;
    shift_en = 1'b0;
    case (r_state)
      S_IDLE:    if (w_accept) w_next = S_CAPTURE;
      S_CAPTURE: begin
        shift_en = 1'b1;
        w_next   = S_FIR;
      end
      S_FIR: begin
        mac_en  = 1'b1;
        tap_idx = r_cnt[TW-1:0];
        acc_clr = (r_cnt == '0);
        if (r_cnt == C_TAP_LAST) w_next = S_FDRAIN;
      end
      S_FDRAIN:  if (r_cnt == C_PIPE_LAST) w_next = S_OUTPUT;
      S_OUTPUT:  w_next = r_bypass ? S_IDLE : S_LMS;
      S_LMS: begin
        mac_en  = 1'b1;
        mac_op  = 1'b1;
        tap_idx = r_cnt[TW-1:0];
        if (r_cnt == C_TAP_LAST) w_next = S_LDRAIN;
      end
      S_LDRAIN:  if (r_cnt == C_PIPE_LAST) w_next = S_IDLE;
      default:   w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                 r_cnt <= '0;
    else if (w_next != r_state) r_cnt <= '0;
    else if (r_state != S_IDLE) r_cnt <= r_cnt + 1'b1;
  end

  // Step-size product; only (-32768)^2 can overflow, but both rails are kept.
  always_comb begin
    w_prod    = r_u * r_e;
    w_prod_sh = w_prod >>> 15;
    if (w_prod_sh > C_P_MAX)      w_mu_sat = 16'sh7FFF;
    else if (w_prod_sh < C_P_MIN) w_mu_sat = -16'sh8000;
    else                          w_mu_sat = w_prod_sh[15:0];
  end

  always_comb begin
    w_acc_sh = acc_in >>> SHIFT;
    w_diff   = (ACCW + 1)'(r_a) - (ACCW + 1)'(w_acc_sh);
    if (w_diff > C_O_MAX)      w_out_sat = 16'sh7FFF;
    else if (w_diff < C_O_MIN) w_out_sat = -16'sh8000;
    else                       w_out_sat = w_diff[15:0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_e          <= '0;
      r_a          <= '0;
      r_u          <= '0;
      r_x_cur      <= '0;
      r_bypass     <= 1'b0;
      r_mu_e       <= '0;
      r_out_sample <= '0;
      r_out_valid  <= 1'b0;
    end else begin
      if (w_accept) begin
        r_e      <= e_in;
        r_a      <= a_in;
        r_u      <= u_in;
        r_x_cur  <= x_in;
        r_bypass <= bypass_mode_sel;
      end
      if (r_state == S_CAPTURE) r_mu_e <= w_mu_sat;
      if (r_state == S_OUTPUT)  r_out_sample <= w_out_sat;
      r_out_valid <= (r_state == S_OUTPUT);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_in_valid_q  <= 1'b0;
      r_overrun_cnt <= '0;
    end else begin
      r_in_valid_q <= in_valid;
      if (in_valid && !r_in_valid_q && (r_state != S_IDLE) && (r_overrun_cnt != 8'hFF))
        r_overrun_cnt <= r_overrun_cnt + 8'd1;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_anc_sample_sequencer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_anc_sample_sequencer
// Description : Directed self-checking bench for anc_sample_sequencer (NTAPS=4, PIPE=2).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_anc_sample_sequencer;

  localparam int NTAPS = 4;
  localparam int PIPE  = 2;
  localparam int ACCW  = 40;
  localparam int SHIFT = 15;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        init_done;
  logic        bypass_mode_sel;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] e_in, x_in, a_in, u_in;
  logic [15:0] x_cur, mu_e, out_sample;
  logic        mac_en, mac_op, acc_clr, shift_en, out_valid, busy;
  logic [1:0]  tap_idx;
  logic [39:0] acc_in;
  logic [7:0]  overrun_cnt;

  int n_tests = 0;
  int n_fail  = 0;

  anc_sample_sequencer #(.NTAPS(NTAPS), .PIPE(PIPE), .ACCW(ACCW), .SHIFT(SHIFT)) dut (
    .clk(clk), .rst_n(rst_n), .init_done(init_done), .bypass_mode_sel(bypass_mode_sel),
    .in_valid(in_valid), .in_ready(in_ready),
    .e_in(e_in), .x_in(x_in), .a_in(a_in), .u_in(u_in),
    .x_cur(x_cur), .mu_e(mu_e), .mac_en(mac_en), .mac_op(mac_op), .tap_idx(tap_idx),
    .acc_clr(acc_clr), .shift_en(shift_en), .acc_in(acc_in),
    .out_sample(out_sample), .out_valid(out_valid), .busy(busy), .overrun_cnt(overrun_cnt)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ready(input int budget, input string tag);
    int i = 0;
    while (!in_ready && i < budget) begin
      step();
      i++;
    end
    check(tag, {63'b0, in_ready}, 64'd1);
  endtask

  function automatic logic [63:0] all_outs();
    return {in_ready, mac_en, mac_op, tap_idx, acc_clr, shift_en, x_cur, mu_e,
            out_sample, out_valid, busy, overrun_cnt};
  endfunction

  // Accept one set at the current cycle (k=0) and check every cycle up to k=last.
  task automatic run_iter(input string tag, input logic [15:0] e, input logic [15:0] x,
                          input logic [15:0] a, input logic [15:0] u, input logic [39:0] acc,
                          input logic byp, input logic tog,
                          input logic [15:0] exp_mu, input logic [15:0] exp_out);
    int last = byp ? 9 : 15;
    logic [8:0] ev, gv;
    e_in = e; x_in = x; a_in = a; u_in = u; acc_in = acc;
    bypass_mode_sel = byp;
    in_valid = 1'b1;
    check({tag, ".accept"}, {63'b0, in_ready}, 64'd1);
    step();
    in_valid = 1'b0;
    for (int k = 1; k <= last; k++) begin
      ev = '0;
      if (k >= 2 && k <= 5) begin
        ev[8] = 1'b1; ev[7] = 1'b0; ev[6:5] = 2'(k - 2); ev[4] = (k == 2);
      end
      if (!byp && k >= 9 && k <= 12) begin
        ev[8] = 1'b1; ev[7] = 1'b1; ev[6:5] = 2'(k - 9);
      end
      ev[3] = (k == 1);
      ev[2] = (k == 9);
      ev[1] = (k == last);
      ev[0] = (k != last);
      gv = {mac_en, mac_op, tap_idx, acc_clr, shift_en, out_valid, in_ready, busy};
      check($sformatf("%s.sched.k%0d", tag, k), {55'b0, gv}, {55'b0, ev});
      if (k == 1) check({tag, ".x_cur"}, {48'b0, x_cur}, {48'b0, x});
      if (k == 2) check({tag, ".mu_e"}, {48'b0, mu_e}, {48'b0, exp_mu});
      if (k == 9) check({tag, ".out"}, {48'b0, out_sample}, {48'b0, exp_out});
      if (tog && k == 4) bypass_mode_sel = ~byp;
      if (k < last) step();
    end
  endtask

  initial begin
    logic seen_ov;
    rst_n = 1'b0; init_done = 1'b0; bypass_mode_sel = 1'b0; in_valid = 1'b0;
    e_in = '0; x_in = '0; a_in = '0; u_in = '0; acc_in = '0;
    #1;
    check("reset.outs", all_outs(), 64'd0);
    step(); step();
    rst_n = 1'b1;
    step();
    check("reset.after", all_outs(), 64'd0);

    // No accept while configuration is not loaded.
    in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      check($sformatf("gate.c%0d", i), {62'b0, in_ready, busy}, 64'd0);
      step();
    end
    in_valid = 1'b0;
    init_done = 1'b1;
    step();

    run_iter("basic", 16'h7FFF, 16'h1234, 16'h0064, 16'h7FFF, 40'h00_0000_8000,
             1'b0, 1'b0, 16'h7FFE, 16'h0063);
    run_iter("satneg", 16'h8000, 16'hABCD, 16'h8000, 16'h8000, 40'h00_0005_0000,
             1'b1, 1'b1, 16'h7FFF, 16'h8000);
    run_iter("neg", 16'hFC18, 16'h0001, 16'hFFFB, 16'h4000, 40'hFF_FFFF_0000,
             1'b0, 1'b1, 16'hFE0C, 16'hFFFD);
    run_iter("satpos", 16'h0003, 16'h7FFF, 16'h7FFF, 16'h0002, 40'hFF_FFFB_0000,
             1'b1, 1'b0, 16'h0000, 16'h7FFF);

    // Three rising edges of in_valid while busy.
    bypass_mode_sel = 1'b0;
    in_valid = 1'b1;
    step();
    for (int k = 1; k < 15; k++) begin
      in_valid = (k == 3 || k == 5 || k == 7);
      step();
    end
    in_valid = 1'b0;
    check("ovr.ready", {63'b0, in_ready}, 64'd1);
    check("ovr.cnt3", {56'b0, overrun_cnt}, 64'd3);

    // Back-to-back with in_valid held: next accept in the first IDLE cycle.
    bypass_mode_sel = 1'b1;
    in_valid = 1'b1;
    step();
    for (int k = 1; k < 9; k++) step();
    check("b2b.ready_k9", {63'b0, in_ready}, 64'd1);
    step();
    check("b2b.capture_k10", {62'b0, busy, shift_en}, 64'd3);
    in_valid = 1'b0;
    wait_ready(40, "b2b.done");
    check("b2b.no_ovr", {56'b0, overrun_cnt}, 64'd3);

    // Many overruns saturate the counter.
    bypass_mode_sel = 1'b0;
    for (int i = 0; i < 1200; i++) begin
      in_valid = (i % 2 == 0);
      step();
    end
    in_valid = 1'b0;
    wait_ready(40, "ovr.sat_done");
    check("ovr.cnt255", {56'b0, overrun_cnt}, 64'd255);

    // Asynchronous reset during the FIR pass.
    e_in = 16'h0100; u_in = 16'h0100; x_in = 16'h5A5A; a_in = 16'h0010;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    step(); step();
    check("rst.in_fir", {62'b0, mac_en, busy}, 64'd3);
    check("rst.mu_set", {48'b0, mu_e}, 64'd2);
    #1;
    rst_n = 1'b0;
    #1;
    check("rst.async_outs", all_outs(), 64'd0);
    step();
    check("rst.held_outs", all_outs(), 64'd0);
    rst_n = 1'b1;
    seen_ov = 1'b0;
    for (int i = 0; i < 15; i++) begin
      step();
      if (out_valid) seen_ov = 1'b1;
    end
    check("rst.no_out_valid", {63'b0, seen_ov}, 64'd0);
    check("rst.idle", {62'b0, busy, in_ready}, 64'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/anc_sample_sequencer.md
# anc_sample_sequencer

Per-sample control FSM for the ANC core. It accepts one merged {e, x, a, u} sample set from the I2S receiver merge handshake, then time-shares a single external MAC datapath: first for the FIR output pass, then for the LMS weight-update pass. It produces the saturated anti-noise output sample with a one-cycle valid pulse for the I2S transmitter, and counts overruns when a new sample set arrives while an iteration is in progress.

## Interface
- NTAPS, 32: FIR/LMS taps per pass; power of two, ≥2.
- PIPE, 2: MAC pipeline depth; cycles to drain after the last tap issue.
- ACCW, 40: accumulator width returned by the MAC.
- SHIFT, 15: arithmetic right shift applied to acc_in before output.
- clk  in  1  core clock.
- rst_n  in  1  asynchronous, active-low reset.
- init_done  in  1  configuration loaded; no sample is accepted while low.
- bypass_mode_sel  in  1  1 = skip LMS pass (weights externally injected).
- in_valid  in  1  merged sample set valid.
- in_ready  out  1  sequencer accepts a sample set this cycle.
- e_in, x_in, a_in, u_in  in  16 each  signed error, reference, audio and step size.
- x_cur  out  16  captured x sample, for the datapath delay line.
- mu_e  out  16  registered sat16((u·e) >>> 15).
- mac_en  out  1  MAC issue strobe.
- mac_op  out  1  0 = FIR accumulate, 1 = LMS update.
- tap_idx  out  log2(NTAPS)  tap index being issued.
- acc_clr  out  1  clear the accumulator together with tap 0 of the FIR pass.
- shift_en  out  1  one-cycle pulse: push x_cur into the delay line.
- acc_in  in  ACCW  signed accumulator result from the MAC.
- out_sample  out  16  signed output sample.
- out_valid  out  1  one-cycle pulse; out_sample is new in that cycle.
- busy  out  1  state ≠ IDLE.
- overrun_cnt  out  8  saturating overrun count.

## Operation
- States: IDLE, CAPTURE, FIR, FDRAIN, OUTPUT, LMS, LDRAIN.
- in_ready = (state==IDLE) & init_done. A sample set is accepted when in_valid & in_ready.
- On accept: latch e, x, a, u and bypass_mode_sel into internal registers, then go to CAPTURE.
- CAPTURE (1 cycle):
  - Compute the 32-bit product u·e, shift it arithmetically right by 15, saturate to [-32768, 32767] and register it as mu_e.
  - Drive x_cur from the latched x. Pulse shift_en.
  - Go to FIR.
- FIR (NTAPS cycles): mac_en=1, mac_op=0, tap_idx counts 0..NTAPS-1, acc_clr=1 only when tap_idx=0. Then go to FDRAIN.
- FDRAIN (PIPE cycles): mac_en=0. Then go to OUTPUT.
- OUTPUT (1 cycle):
  - Compute out = sat16(a_latched − (acc_in >>> SHIFT)). The subtraction is done at ACCW+1 bits before saturation.
  - Register out into out_sample.
  - Go to LMS, or to IDLE if the latched bypass bit is 1.
- LMS (NTAPS cycles): mac_en=1, mac_op=1, tap_idx 0..NTAPS-1. Then go to LDRAIN.
- LDRAIN (PIPE cycles): then go to IDLE.
- Overrun: count a rising edge of in_valid (registered previous value 0, current value 1) while state≠IDLE. overrun_cnt saturates at 255. The set is not dropped; it is accepted on return to IDLE.
- bypass_mode_sel changes mid-iteration affect the next iteration only.
- init_done low mid-iteration: the current iteration completes; no new accept.

## Timing
- Reset values: in_ready=0, mac_en=0, mac_op=0, tap_idx=0, acc_clr=0, shift_en=0, x_cur=0, mu_e=0, out_sample=0, out_valid=0, busy=0, overrun_cnt=0, state=IDLE.
- Accept at cycle T:
  - CAPTURE at T+1; shift_en high at T+1.
  - First FIR issue at T+2; last FIR issue at T+1+NTAPS.
  - OUTPUT at T+2+NTAPS+PIPE. out_valid and the new out_sample appear at T+3+NTAPS+PIPE for exactly 1 cycle.
  - LMS starts at T+3+NTAPS+PIPE.
- Iteration length (accept to in_ready high again): 3+NTAPS+PIPE with bypass; 3+2·(NTAPS+PIPE) without.
- Back-to-back: if in_valid is held high, the next accept happens in the first IDLE cycle; there is no dead cycle beyond that.
- Asynchronous reset mid-iteration: immediate return to IDLE with all outputs at reset values. No partial out_valid is emitted.

## Test plan
- NTAPS=4, PIPE=2, bypass=0:
  - Stimulus: accept at T; acc_in stubbed to 0x00_0000_8000 (32768 → 1 after >>>15); a=100.
  - Required: out_sample=99 with out_valid at T+9 only; tap_idx sequences 0,1,2,3 for mac_op=0 at T+2..T+5 and for mac_op=1 at T+9..T+12; in_ready returns at T+15.
- Saturation:
  - Stimulus: u=0x7FFF, e=0x7FFF. Required: mu_e=32766.
  - Stimulus: u=−32768, e=−32768. Required: mu_e=32767 (saturated).
  - Stimulus: a=−32768 and acc_in>>>SHIFT=+10. Required: out_sample=−32768.
- Bypass: latch bypass=1 at accept.
  - Required: no mac_op=1 issue; in_ready is high again 9 cycles after accept.
  - Toggling bypass_mode_sel mid-iteration does not alter the running iteration.
- Overrun:
  - Stimulus: pulse in_valid low→high 3 times during an iteration. Required: overrun_cnt=3.
  - Stimulus: force 300 overruns. Required: overrun_cnt=255.
- Gating/reset:
  - Stimulus: init_done=0 with in_valid=1. Required: in_ready=0, no accept.
  - Stimulus: assert rst_n low during the FIR pass. Required: all outputs return to reset values asynchronously; no out_valid is produced.
